instruction_fetch_unit: RTL and testbench

- Upstream producer for the datapath controller's opcode input.
- Fetches 32-bit MIPS instructions from an instruction memory with variable response latency, one outstanding request at a time, and holds each one in an instruction register.
- Presents the decoded fields (OpCode, Rs, Rt, Rd, Shamt, Funct, Imm) to the controller and datapath, with a valid/stall handshake and branch redirect.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/inst_field_splitter.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch unit and the datapath controller:
// fetch FSM encoding, the idle opcode, MIPS field positions and reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } fetch_state_e;

  // The controller's no-op initial state decodes from this opcode.
  localparam logic [5:0]  IDLE_OPCODE      = 6'b111111;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/inst_field_splitter.sv
// Slices the held MIPS instruction into its fields; OpCode falls back to
// the idle opcode whenever no valid instruction is held.
module inst_field_splitter #(
  parameter logic [5:0] IDLE_OPCODE = cpu_pkg::IDLE_OPCODE
) (
  input  logic [31:0] instruction_i,
  input  logic        instValid_i,
  output logic [5:0]  opCode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o
);
  import cpu_pkg::*;

  assign opCode_o = instValid_i ? instruction_i[OPCODE_MSB:OPCODE_LSB] : IDLE_OPCODE;
  assign rs_o     = instruction_i[RS_MSB:RS_LSB];
  assign rt_o     = instruction_i[RT_MSB:RT_LSB];
  assign rd_o     = instruction_i[RD_MSB:RD_LSB];
  assign shamt_o  = instruction_i[SHAMT_MSB:SHAMT_LSB];
  assign funct_o  = instruction_i[FUNCT_MSB:FUNCT_LSB];
  assign imm_o    = instruction_i[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM with one outstanding memory request, an instruction register,
// a valid/stall handshake to the controller and branch redirect.
module instruction_fetch_unit #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(cpu_pkg::RESET_PC_DEFAULT),
  parameter logic [5:0]           IDLE_OPCODE = cpu_pkg::IDLE_OPCODE
) (
  input  logic                Clk,
  input  logic                Rst,
  output logic                ImemReq,
  output logic [PC_WIDTH-1:0] ImemAddr,
  input  logic                ImemValid,
  input  logic [31:0]         ImemData,
  input  logic                Stall,
  input  logic                Redirect,
  input  logic [PC_WIDTH-1:0] RedirectPC,
  output logic                InstValid,
  output logic [31:0]         Instruction,
  output logic [5:0]          OpCode,
  output logic [4:0]          Rs,
  output logic [4:0]          Rt,
  output logic [4:0]          Rd,
  output logic [4:0]          Shamt,
  output logic [5:0]          Funct,
  output logic [15:0]         Imm,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4
);
  import cpu_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pcPlus4_q;
  logic [31:0]         instr_q, instr_d;
  logic                instValid_q, instValid_d;
  logic                discard_q, discard_d;
  logic                imemReq_q;
  logic [PC_WIDTH-1:0] redirectAligned;

  assign redirectAligned = RedirectPC & ~PC_WIDTH'(3);

  // Discard marks a response already in flight that belongs to a path the
  // redirect abandoned; it is swallowed when it arrives instead of issued.
  always_comb begin
    state_d     = state_q;
    fetchPc_d   = fetchPc_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instValid_d = instValid_q;
    discard_d   = discard_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        state_d = ST_WAIT;
        if (Redirect) begin
          fetchPc_d = redirectAligned;
          discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (Redirect) begin
          fetchPc_d = redirectAligned;
          if (ImemValid) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (ImemValid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            instr_d     = ImemData;
            pc_d        = fetchPc_q;
            fetchPc_d   = fetchPc_q + PC_WIDTH'(4);
            instValid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (Redirect) begin
          fetchPc_d   = redirectAligned;
          instValid_d = 1'b0;
          state_d     = ST_REQ;
        end else if (!Stall) begin
          instValid_d = 1'b0;
          state_d     = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      fetchPc_q   <= RESET_PC;
      pc_q        <= RESET_PC;
      pcPlus4_q   <= RESET_PC + PC_WIDTH'(4);
      instr_q     <= '0;
      instValid_q <= 1'b0;
      discard_q   <= 1'b0;
      imemReq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetchPc_q   <= fetchPc_d;
      pc_q        <= pc_d;
      pcPlus4_q   <= pc_d + PC_WIDTH'(4);
      instr_q     <= instr_d;
      instValid_q <= instValid_d;
      discard_q   <= discard_d;
      imemReq_q   <= (state_d == ST_REQ);
    end
  end

  assign ImemReq     = imemReq_q;
  assign ImemAddr    = fetchPc_q;
  assign InstValid   = instValid_q;
  assign Instruction = instr_q;
  assign PC          = pc_q;
  assign PCPlus4     = pcPlus4_q;

  inst_field_splitter #(
    .IDLE_OPCODE(IDLE_OPCODE)
  ) u_splitter (
    .instruction_i(instr_q),
    .instValid_i  (instValid_q),
    .opCode_o     (OpCode),
    .rs_o         (Rs),
    .rt_o         (Rt),
    .rd_o         (Rd),
    .shamt_o      (Shamt),
    .funct_o      (Funct),
    .imm_o        (Imm)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: one scripted cycle sequence
// with hand-computed expectations checked by immediate assertions.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstValid;
  logic [31:0] Instruction;
  logic [5:0]  OpCode;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemValid  (ImemValid),
    .ImemData   (ImemData),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .InstValid  (InstValid),
    .Instruction(Instruction),
    .OpCode     (OpCode),
    .Rs         (Rs),
    .Rt         (Rt),
    .Rd         (Rd),
    .Shamt      (Shamt),
    .Funct      (Funct),
    .Imm        (Imm),
    .PC         (PC),
    .PCPlus4    (PCPlus4)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic redirect,
                               input logic [31:0] redirectPc, input logic valid,
                               input logic [31:0] data);
    Rst        = rst;
    Stall      = stall;
    Redirect   = redirect;
    RedirectPC = redirectPc;
    ImemValid  = valid;
    ImemData   = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Idle-side expectations: request line, address and the invalid-instruction view.
  task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid);
    checkOutput({tag, ".req"}, 32'(ImemReq), 32'(req));
    if (req) checkOutput({tag, ".addr"}, ImemAddr, addr);
    checkOutput({tag, ".valid"}, 32'(InstValid), 32'(valid));
    if (!valid) checkOutput({tag, ".opIdle"}, 32'(OpCode), 32'h3F);
  endtask

  initial begin
    $display("[TB] starting instruction_fetch_unit directed test");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    tick();
    checkOutput("rst.req", 32'(ImemReq), 32'h0);
    checkOutput("rst.valid", 32'(InstValid), 32'h0);
    checkOutput("rst.instr", Instruction, 32'h0);
    checkOutput("rst.opcode", 32'(OpCode), 32'h3F);
    checkOutput("rst.pc", PC, 32'h0);
    checkOutput("rst.addr", ImemAddr, 32'h0);
    tick();

    // Cycle 0 IDLE, cycle 1 REQ addr 0, cycle 2 WAIT with latency-1 response
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFetch("c0", 1'b0, 32'h0, 1'b0);
    tick();
    checkFetch("c1", 1'b1, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2108_0005);
    checkFetch("c2", 1'b0, 32'h0, 1'b0);

    // Cycles 3..7 ISSUE, stalled for 4 cycles then released
    for (int c = 3; c <= 7; c++) begin
      tick();
      applyStimulus(1'b1, (c < 7), 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput($sformatf("c%0d.valid", c), 32'(InstValid), 32'h1);
      checkOutput($sformatf("c%0d.req", c), 32'(ImemReq), 32'h0);
      checkOutput($sformatf("c%0d.instr", c), Instruction, 32'h2108_0005);
      checkOutput($sformatf("c%0d.opcode", c), 32'(OpCode), 32'h08);
      checkOutput($sformatf("c%0d.rs", c), 32'(Rs), 32'd8);
      checkOutput($sformatf("c%0d.rt", c), 32'(Rt), 32'd8);
      checkOutput($sformatf("c%0d.imm", c), 32'(Imm), 32'h0005);
      checkOutput($sformatf("c%0d.funct", c), 32'(Funct), 32'h05);
      checkOutput($sformatf("c%0d.pc", c), PC, 32'h0);
      checkOutput($sformatf("c%0d.pc4", c), PCPlus4, 32'h4);
    end

    // Cycle 8 REQ addr 4; cycle 9 redirect in WAIT; response at cycle 11 discarded
    tick();
    checkFetch("c8", 1'b1, 32'h4, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b0, 32'h0);
    checkFetch("c9", 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFetch("c10", 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    checkFetch("c11", 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFetch("c12", 1'b1, 32'h40, 1'b0);

    // Cycle 13 redirect coincides with the response: data dropped, refetch 0x100
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h8C22_0010);
    checkFetch("c13", 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFetch("c14", 1'b1, 32'h100, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0043_2020);
    checkFetch("c15", 1'b0, 32'h0, 1'b0);

    // Cycle 16 ISSUE of an R-type; redirect with stall forces refetch at 0xFFFFFFFC
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
    checkOutput("c16.valid", 32'(InstValid), 32'h1);
    checkOutput("c16.opcode", 32'(OpCode), 32'h00);
    checkOutput("c16.rs", 32'(Rs), 32'd2);
    checkOutput("c16.rt", 32'(Rt), 32'd3);
    checkOutput("c16.rd", 32'(Rd), 32'd4);
    checkOutput("c16.shamt", 32'(Shamt), 32'd0);
    checkOutput("c16.funct", 32'(Funct), 32'h20);
    checkOutput("c16.pc", PC, 32'h100);
    checkOutput("c16.pc4", PCPlus4, 32'h104);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFetch("c17", 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3C01_1234);
    checkFetch("c18", 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("c19.valid", 32'(InstValid), 32'h1);
    checkOutput("c19.pc", PC, 32'hFFFF_FFFC);
    checkOutput("c19.pc4", PCPlus4, 32'h0);
    checkOutput("c19.opcode", 32'(OpCode), 32'h0F);
    checkOutput("c19.imm", 32'(Imm), 32'h1234);
    tick();
    checkFetch("c20", 1'b1, 32'h0, 1'b0);

    // Cycle 21 WAIT: reset asserted, late response in cycle 22 must be ignored
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    checkFetch("c22", 1'b0, 32'h0, 1'b0);
    checkOutput("c22.instr", Instruction, 32'h0);
    checkOutput("c22.pc", PC, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkFetch("c23", 1'b1, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0800_0010);
    checkFetch("c24", 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("c25.valid", 32'(InstValid), 32'h1);
    checkOutput("c25.instr", Instruction, 32'h0800_0010);
    checkOutput("c25.opcode", 32'(OpCode), 32'h02);
    checkOutput("c25.pc", PC, 32'h0);
    checkOutput("c25.pc4", PCPlus4, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
